// File: rtl/pipelined_cla_pkg.sv
// Shared constants, stage record and helpers for the pipelined carry-lookahead adder/subtractor.
package pipelined_cla_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GROUP = 8;
  localparam int SAT_MAX_WIDTH = 256;

  // Pipeline depth: one lookahead group resolved per stage.
  function automatic int stages(input int width, input int group);
    return (group < 1) ? 1 : width / group;
  endfunction

  function automatic logic [SAT_MAX_WIDTH-1:0] max_pos(input int width);
    return (SAT_MAX_WIDTH'(1) << (width - 1)) - SAT_MAX_WIDTH'(1);
  endfunction

  function automatic logic [SAT_MAX_WIDTH-1:0] max_neg(input int width);
    return SAT_MAX_WIDTH'(1) << (width - 1);
  endfunction

  typedef struct packed {
    logic                     valid;
    logic                     carry;
    logic [DEFAULT_WIDTH-1:0] a;
    logic [DEFAULT_WIDTH-1:0] b;
    logic [DEFAULT_WIDTH-1:0] sum;
  } stage_t;

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// GROUP-bit combinational carry-lookahead group; every carry is a flat sum of
// generate/propagate products, so nothing ripples inside the group.
module cla_group #(
  parameter int GROUP = 8
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             term;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = (cin & p[0..i-1]) | OR_j (g[j] & p[j+1..i-1])
  always_comb begin
    c    = '0;
    term = 1'b0;
    for (int i = 0; i <= GROUP; i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
  end

  assign sum  = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor with valid/ready flow control.
// Define PIPELINED_CLA_SATURATE_EN to clamp signed-overflow results to MAX_POS / MAX_NEG.
module pipelined_cla_addsub
  import pipelined_cla_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = stages(WIDTH, GROUP);
  localparam int LAST   = STAGES - 1;

  if ((GROUP < 1) || (WIDTH % ((GROUP < 1) ? 1 : GROUP) != 0) || (WIDTH < 1)) begin : g_bad_params
    $error("pipelined_cla_addsub: WIDTH (%0d) must be a positive multiple of GROUP (%0d)", WIDTH, GROUP);
  end

  // Same layout as pipelined_cla_pkg::stage_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
  } stage_reg_t;

  stage_reg_t       st       [STAGES];
  logic [GROUP-1:0] grp_sum  [STAGES];
  logic             grp_cout [STAGES];
  logic             grp_cmsb [STAGES];
  logic             en;
  logic [WIDTH-1:0] raw_sum;

  assign out_valid = st[LAST].valid;
  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_group #(.GROUP(GROUP)) u_group (
      .a    (st[k].a[k*GROUP +: GROUP]),
      .b    (st[k].b[k*GROUP +: GROUP]),
      .cin  (st[k].carry),
      .sum  (grp_sum[k]),
      .cout (grp_cout[k]),
      .cmsb (grp_cmsb[k])
    );
  end

  // Whole pipeline advances or holds together; each stage hands its group's
  // sum slice and carry to the next while the operands travel alongside.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    end else if (en) begin
      st[0].valid <= in_valid;
      st[0].carry <= sub;
      st[0].a     <= a;
      st[0].b     <= b ^ {WIDTH{sub}};
      st[0].sum   <= '0;
      for (int k = 1; k < STAGES; k++) begin
        st[k]                           <= st[k-1];
        st[k].sum[(k-1)*GROUP +: GROUP] <= grp_sum[k-1];
        st[k].carry                     <= grp_cout[k-1];
      end
    end
  end

  always_comb begin
    raw_sum                       = st[LAST].sum;
    raw_sum[LAST*GROUP +: GROUP]  = grp_sum[LAST];
  end

  assign carry_out = grp_cout[LAST];
  assign overflow  = grp_cmsb[LAST] ^ grp_cout[LAST];

`ifdef PIPELINED_CLA_SATURATE_EN
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(max_neg(WIDTH));

  // A wrapped sign bit of 1 means the true result was positive.
  assign sum = overflow ? (raw_sum[WIDTH-1] ? MAX_POS : MAX_NEG) : raw_sum;
`else
  assign sum = raw_sum;
`endif

  assign zero = out_valid & (sum == '0);

endmodule
